mbinit_param_resp: RTL and testbench

- Partner-side responder for the MBINIT.PARAM exchange.
- Consumes the MBINIT.PARAM configuration_req (sideband code 4'b0001) produced by the far-side requester, together with its parameter fields.
- Negotiates the link parameters against local capabilities and returns configuration_resp (4'b0010) carrying the negotiated values.
- Signals done or train-error to the MBINIT sequencer; runs concurrently with the local requester during MBINIT.PARAM.

---
 rtl/mbinit_pkg.sv | 25 ++
 rtl/mbinit_param_resp_if.sv | 31 +++
 rtl/mbinit_param_resp_negotiator.sv | 32 +++
 rtl/mbinit_param_resp.sv | 154 +++++++++++++++
 tb/tb_mbinit_param_resp.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mbinit_pkg.sv
// Shared MBINIT definitions: sideband codes, legal rate limit,
// clock-mode/phase encodings and FSM state constants.
package mbinit_pkg;

  localparam logic [3:0] MBINIT_PARAM_configuration_req  = 4'b0001;
  localparam logic [3:0] MBINIT_PARAM_configuration_resp = 4'b0010;

  localparam logic [2:0] MAX_RATE_LEGAL = 3'd5;

  localparam logic CLK_MODE_STROBE = 1'b0;
  localparam logic CLK_MODE_CONT   = 1'b1;
  localparam logic PHASE_DIFF      = 1'b0;
  localparam logic PHASE_QUAD      = 1'b1;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WAIT_REQ  = 3'd1;
  localparam state_t ST_EVAL      = 3'd2;
  localparam state_t ST_SEND_RESP = 3'd3;
  localparam state_t ST_WAIT_TX   = 3'd4;
  localparam state_t ST_DONE      = 3'd5;
  localparam state_t ST_ERROR     = 3'd6;

endpackage

// File: rtl/mbinit_param_resp_if.sv
// Sideband bundle between the MBINIT.PARAM responder (slave) and the
// sideband RX decoder / TX engine (master).
interface mbinit_param_resp_if;
  logic [3:0] i_RX_SbMessage;
  logic       i_msg_valid;
  logic [2:0] i_RX_MaxDataRate;
  logic       i_RX_ClockMode;
  logic       i_RX_PhaseClock;
  logic [4:0] i_RX_VoltageSwing;
  logic       i_Busy_SideBand;
  logic       i_falling_edge_busy;
  logic [3:0] o_tx_sb_msg;
  logic       o_tx_msg_valid;
  logic [2:0] o_tx_max_data_rate;
  logic       o_tx_clock_mode;
  logic       o_tx_phase_clock;

  modport slave (
    input  i_RX_SbMessage, i_msg_valid, i_RX_MaxDataRate, i_RX_ClockMode,
           i_RX_PhaseClock, i_RX_VoltageSwing, i_Busy_SideBand, i_falling_edge_busy,
    output o_tx_sb_msg, o_tx_msg_valid, o_tx_max_data_rate, o_tx_clock_mode,
           o_tx_phase_clock
  );

  modport master (
    output i_RX_SbMessage, i_msg_valid, i_RX_MaxDataRate, i_RX_ClockMode,
           i_RX_PhaseClock, i_RX_VoltageSwing, i_Busy_SideBand, i_falling_edge_busy,
    input  o_tx_sb_msg, o_tx_msg_valid, o_tx_max_data_rate, o_tx_clock_mode,
           o_tx_phase_clock
  );
endinterface

// File: rtl/mbinit_param_resp_negotiator.sv
// param_negotiator: combinational min-rate / capability check shared by
// the responder and the requester-side checker.
import mbinit_pkg::*;

module param_negotiator (
  input  logic [2:0] local_rate,
  input  logic [1:0] local_clk_mode_cap,
  input  logic       local_quad_cap,
  input  logic [2:0] rem_rate,
  input  logic       rem_mode,
  input  logic       rem_phase,
  output logic [2:0] neg_rate,
  output logic       neg_mode,
  output logic       neg_phase,
  output logic       fail
);

  logic mode_ok;
  logic phase_ok;

  // Lowest common rate, echo the remote clocking, flag anything unsupported
  always_comb begin
    neg_rate  = (local_rate < rem_rate) ? local_rate : rem_rate;
    neg_mode  = rem_mode;
    neg_phase = rem_phase;
    mode_ok   = ((rem_mode == CLK_MODE_STROBE) && local_clk_mode_cap[0]) ||
                ((rem_mode == CLK_MODE_CONT)   && local_clk_mode_cap[1]);
    phase_ok  = (rem_phase == PHASE_DIFF) || local_quad_cap;
    fail      = (rem_rate > MAX_RATE_LEGAL) || !mode_ok || !phase_ok;
  end

endmodule

// File: rtl/mbinit_param_resp.sv
// MBINIT.PARAM partner-side responder: accepts configuration_req, negotiates
// against local capabilities and answers with configuration_resp.
// Optional WAIT_REQ timeout enabled by defining PARAM_RESP_TIMEOUT_EN.
import mbinit_pkg::*;

module mbinit_param_resp #(
  parameter int TIMEOUT_CYCLES = 800000,
  parameter int TO_W           = 20
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic                i_MBINIT_Start_en,
  input  logic [2:0]          i_local_max_data_rate,
  input  logic [1:0]          i_local_clk_mode_cap,
  input  logic                i_local_quad_clk_cap,
  mbinit_param_resp_if.slave  sb,
  output logic [2:0]          o_neg_max_data_rate,
  output logic                o_neg_clock_mode,
  output logic                o_neg_phase_clock,
  output logic [4:0]          o_remote_swing,
  output logic                o_resp_done,
  output logic                o_train_error_req
);

  if ((TIMEOUT_CYCLES < 1) || (longint'(TIMEOUT_CYCLES) >= (longint'(1) << TO_W))) begin : g_bad_cfg
    $error("mbinit_param_resp: TO_W too narrow for TIMEOUT_CYCLES");
  end

  state_t     state;
  state_t     state_nxt;
  logic [2:0] cap_rate;
  logic       cap_mode;
  logic       cap_phase;
  logic [2:0] neg_rate;
  logic       neg_mode;
  logic       neg_phase;
  logic       neg_fail;
  logic       req_hit;
  logic       timeout_hit;
  logic [3:0] tx_msg_q;
  logic       tx_valid_q;
  logic [2:0] tx_rate_q;
  logic       tx_mode_q;
  logic       tx_phase_q;

  assign req_hit = sb.i_msg_valid && (sb.i_RX_SbMessage == MBINIT_PARAM_configuration_req);

  param_negotiator u_neg (
    .local_rate         (i_local_max_data_rate),
    .local_clk_mode_cap (i_local_clk_mode_cap),
    .local_quad_cap     (i_local_quad_clk_cap),
    .rem_rate           (cap_rate),
    .rem_mode           (cap_mode),
    .rem_phase          (cap_phase),
    .neg_rate           (neg_rate),
    .neg_mode           (neg_mode),
    .neg_phase          (neg_phase),
    .fail               (neg_fail)
  );

`ifdef PARAM_RESP_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Count cycles spent waiting for a request; restarts on every entry
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)
      to_cnt <= '0;
    else if (!i_MBINIT_Start_en || (state != ST_WAIT_REQ))
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state selection; a low stage enable overrides everything
  always_comb begin
    state_nxt = state;
    if (!i_MBINIT_Start_en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      state_nxt = ST_WAIT_REQ;
        ST_WAIT_REQ:  if (req_hit) state_nxt = ST_EVAL;
                      else if (timeout_hit) state_nxt = ST_ERROR;
        ST_EVAL:      state_nxt = neg_fail ? ST_ERROR : ST_SEND_RESP;
        ST_SEND_RESP: if (!sb.i_Busy_SideBand) state_nxt = ST_WAIT_TX;
        ST_WAIT_TX:   if (sb.i_falling_edge_busy) state_nxt = ST_DONE;
        ST_DONE:      if (req_hit) state_nxt = ST_EVAL;
        ST_ERROR:     state_nxt = ST_ERROR;
        default:      state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, capture and registered outputs decoded from the next state
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n || !i_MBINIT_Start_en) begin
      state               <= ST_IDLE;
      cap_rate            <= '0;
      cap_mode            <= 1'b0;
      cap_phase           <= 1'b0;
      o_remote_swing      <= '0;
      o_neg_max_data_rate <= '0;
      o_neg_clock_mode    <= 1'b0;
      o_neg_phase_clock   <= 1'b0;
      tx_msg_q            <= '0;
      tx_valid_q          <= 1'b0;
      tx_rate_q           <= '0;
      tx_mode_q           <= 1'b0;
      tx_phase_q          <= 1'b0;
      o_resp_done         <= 1'b0;
      o_train_error_req   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (((state == ST_WAIT_REQ) || (state == ST_DONE)) && (state_nxt == ST_EVAL)) begin
        cap_rate       <= sb.i_RX_MaxDataRate;
        cap_mode       <= sb.i_RX_ClockMode;
        cap_phase      <= sb.i_RX_PhaseClock;
        o_remote_swing <= sb.i_RX_VoltageSwing;
      end
      if (state == ST_EVAL) begin
        o_neg_max_data_rate <= neg_rate;
        o_neg_clock_mode    <= neg_mode;
        o_neg_phase_clock   <= neg_phase;
      end
      if ((state == ST_SEND_RESP) && (state_nxt == ST_WAIT_TX)) begin
        tx_msg_q   <= MBINIT_PARAM_configuration_resp;
        tx_valid_q <= 1'b1;
        tx_rate_q  <= o_neg_max_data_rate;
        tx_mode_q  <= o_neg_clock_mode;
        tx_phase_q <= o_neg_phase_clock;
      end else begin
        tx_msg_q   <= '0;
        tx_valid_q <= 1'b0;
        tx_rate_q  <= '0;
        tx_mode_q  <= 1'b0;
        tx_phase_q <= 1'b0;
      end
      o_resp_done       <= (state_nxt == ST_DONE);
      o_train_error_req <= (state_nxt == ST_ERROR);
    end
  end

  assign sb.o_tx_sb_msg        = tx_msg_q;
  assign sb.o_tx_msg_valid     = tx_valid_q;
  assign sb.o_tx_max_data_rate = tx_rate_q;
  assign sb.o_tx_clock_mode    = tx_mode_q;
  assign sb.o_tx_phase_clock   = tx_phase_q;

endmodule

// File: tb/tb_mbinit_param_resp.sv
// Testbench for mbinit_param_resp: directed requests, scoreboard of expected
// configuration_resp strobes (cycle and fields), level checks on done/error.
module tb_mbinit_param_resp;

`ifdef PARAM_RESP_TIMEOUT_EN
  localparam int TB_TIMEOUT = 16;
`else
  localparam int TB_TIMEOUT = 800000;
`endif

  typedef struct {
    int       cyc;
    logic [2:0] rate;
    logic       mode;
    logic       phase;
  } exp_t;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       start_en;
  logic [2:0] local_rate;
  logic [1:0] local_caps;
  logic       local_quad;
  logic [2:0] neg_rate;
  logic       neg_mode;
  logic       neg_phase;
  logic [4:0] remote_swing;
  logic       resp_done;
  logic       train_err;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   cap;
  int   dummy;
  exp_t exp_q[$];

  mbinit_param_resp_if sb ();

  mbinit_param_resp #(.TIMEOUT_CYCLES(TB_TIMEOUT), .TO_W(20)) dut (
    .CLK                   (CLK),
    .rst_n                 (rst_n),
    .i_MBINIT_Start_en     (start_en),
    .i_local_max_data_rate (local_rate),
    .i_local_clk_mode_cap  (local_caps),
    .i_local_quad_clk_cap  (local_quad),
    .sb                    (sb),
    .o_neg_max_data_rate   (neg_rate),
    .o_neg_clock_mode      (neg_mode),
    .o_neg_phase_clock     (neg_phase),
    .o_remote_swing        (remote_swing),
    .o_resp_done           (resp_done),
    .o_train_error_req     (train_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] code, input logic [2:0] rate, input logic mode,
                               input logic phase, input logic [4:0] swing, output int cap_cyc);
    sb.i_msg_valid       = 1'b1;
    sb.i_RX_SbMessage    = code;
    sb.i_RX_MaxDataRate  = rate;
    sb.i_RX_ClockMode    = mode;
    sb.i_RX_PhaseClock   = phase;
    sb.i_RX_VoltageSwing = swing;
    tick(1);
    cap_cyc              = cyc;
    sb.i_msg_valid       = 1'b0;
    sb.i_RX_SbMessage    = 4'b0000;
  endtask

  task automatic pushExp(input int c, input logic [2:0] r, input logic m, input logic p);
    exp_t e;
    e.cyc = c; e.rate = r; e.mode = m; e.phase = p;
    exp_q.push_back(e);
  endtask

  task automatic fePulse();
    sb.i_falling_edge_busy = 1'b1;
    tick(1);
    sb.i_falling_edge_busy = 1'b0;
  endtask

  task automatic restart();
    start_en = 1'b0;
    tick(1);
    start_en = 1'b1;
    tick(1);
  endtask

  // Monitor: every strobe must match the oldest expected response
  always @(negedge CLK) begin
    if (rst_n && sb.o_tx_msg_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_strobe actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("strobe_cycle", cyc, e.cyc);
        checkOutput("strobe_msg", int'(sb.o_tx_sb_msg), 2);
        checkOutput("strobe_rate", int'(sb.o_tx_max_data_rate), int'(e.rate));
        checkOutput("strobe_mode", int'(sb.o_tx_clock_mode), int'(e.mode));
        checkOutput("strobe_phase", int'(sb.o_tx_phase_clock), int'(e.phase));
      end
    end
  end

  initial begin
    rst_n = 1'b0; start_en = 1'b0;
    local_rate = 3'd3; local_caps = 2'b11; local_quad = 1'b1;
    sb.i_msg_valid = 1'b0; sb.i_RX_SbMessage = 4'd0; sb.i_RX_MaxDataRate = 3'd0;
    sb.i_RX_ClockMode = 1'b0; sb.i_RX_PhaseClock = 1'b0; sb.i_RX_VoltageSwing = 5'd0;
    sb.i_Busy_SideBand = 1'b0; sb.i_falling_edge_busy = 1'b0;
    tick(2);
    checkOutput("reset_tx_valid", int'(sb.o_tx_msg_valid), 0);
    checkOutput("reset_done", int'(resp_done), 0);
    checkOutput("reset_err", int'(train_err), 0);
    checkOutput("reset_neg_rate", int'(neg_rate), 0);
    rst_n = 1'b1;
    start_en = 1'b1;
    tick(1);

    // Basic negotiation: rate min(3,5)=3, continuous, differential
    applyStimulus(4'b0001, 3'd5, 1'b1, 1'b0, 5'h15, cap);
    pushExp(cap + 2, 3'd3, 1'b1, 1'b0);
    checkOutput("swing_capture", int'(remote_swing), 21);
    tick(3);
    checkOutput("tx_msg_cleared", int'(sb.o_tx_sb_msg), 0);
    checkOutput("neg_rate_held", int'(neg_rate), 3);
    checkOutput("neg_mode_held", int'(neg_mode), 1);
    fePulse();
    checkOutput("done_basic", int'(resp_done), 1);
    checkOutput("err_basic", int'(train_err), 0);

    // Partner retry while in DONE: rate 1, strobe mode, quadrature
    applyStimulus(4'b0001, 3'd1, 1'b0, 1'b1, 5'h03, cap);
    pushExp(cap + 2, 3'd1, 1'b0, 1'b1);
    checkOutput("done_drops_retry", int'(resp_done), 0);
    tick(3);
    checkOutput("neg_phase_retry", int'(neg_phase), 1);
    fePulse();
    checkOutput("done_retry", int'(resp_done), 1);

    // Request in the same cycle Start_en falls is dropped
    start_en = 1'b0;
    applyStimulus(4'b0001, 3'd2, 1'b1, 1'b0, 5'h1F, dummy);
    checkOutput("startlow_done", int'(resp_done), 0);
    checkOutput("startlow_swing", int'(remote_swing), 0);
    checkOutput("startlow_neg", int'(neg_rate), 0);
    start_en = 1'b1;
    tick(4);
    checkOutput("after_startlow_done", int'(resp_done), 0);

    // Non-request codes ignored in WAIT_REQ
    applyStimulus(4'b0011, 3'd2, 1'b1, 1'b0, 5'h07, dummy);
    tick(3);
    checkOutput("other_code_swing", int'(remote_swing), 0);

    // Illegal rate -> error, held, later requests ignored, cleared by Start_en low
    applyStimulus(4'b0001, 3'd6, 1'b1, 1'b0, 5'h01, dummy);
    tick(1);
    checkOutput("rate6_err", int'(train_err), 1);
    checkOutput("rate6_done", int'(resp_done), 0);
    applyStimulus(4'b0001, 3'd2, 1'b1, 1'b0, 5'h02, dummy);
    tick(3);
    checkOutput("err_held", int'(train_err), 1);
    checkOutput("err_no_recapture", int'(remote_swing), 1);
    start_en = 1'b0;
    tick(1);
    checkOutput("err_cleared", int'(train_err), 0);
    start_en = 1'b1;
    tick(1);

    // Continuous mode unsupported
    local_caps = 2'b01;
    applyStimulus(4'b0001, 3'd2, 1'b1, 1'b0, 5'h00, dummy);
    tick(1);
    checkOutput("mode_cap_err", int'(train_err), 1);
    restart();

    // Quadrature unsupported
    local_caps = 2'b11;
    local_quad = 1'b0;
    applyStimulus(4'b0001, 3'd2, 1'b0, 1'b1, 5'h00, dummy);
    tick(1);
    checkOutput("quad_cap_err", int'(train_err), 1);
    restart();
    local_quad = 1'b1;

    // Busy held 10 cycles; extra requests in EVAL/SEND_RESP ignored
    sb.i_Busy_SideBand = 1'b1;
    applyStimulus(4'b0001, 3'd4, 1'b0, 1'b0, 5'h0A, cap);
    pushExp(cap + 11, 3'd3, 1'b0, 1'b0);
    applyStimulus(4'b0001, 3'd1, 1'b1, 1'b1, 5'h11, dummy);
    applyStimulus(4'b0001, 3'd0, 1'b1, 1'b1, 5'h12, dummy);
    tick(8);
    sb.i_Busy_SideBand = 1'b0;
    tick(3);
    checkOutput("busy_no_recapture", int'(remote_swing), 10);
    fePulse();
    checkOutput("busy_done", int'(resp_done), 1);
    restart();

    // Start_en dropped in WAIT_TX, then a fresh exchange
    applyStimulus(4'b0001, 3'd2, 1'b1, 1'b1, 5'h05, cap);
    pushExp(cap + 2, 3'd2, 1'b1, 1'b1);
    tick(3);
    start_en = 1'b0;
    tick(1);
    checkOutput("waittx_abort_neg", int'(neg_rate), 0);
    start_en = 1'b1;
    tick(1);
    fePulse();
    checkOutput("stray_fe_done", int'(resp_done), 0);
    applyStimulus(4'b0001, 3'd0, 1'b0, 1'b0, 5'h06, cap);
    pushExp(cap + 2, 3'd0, 1'b0, 1'b0);
    tick(3);
    fePulse();
    checkOutput("fresh_done", int'(resp_done), 1);

`ifdef PARAM_RESP_TIMEOUT_EN
    // Timeout after 16 cycles in WAIT_REQ; a request on cycle 16 wins
    restart();
    tick(15);
    checkOutput("timeout_early", int'(train_err), 0);
    tick(1);
    checkOutput("timeout_err", int'(train_err), 1);
    restart();
    tick(15);
    applyStimulus(4'b0001, 3'd5, 1'b1, 1'b0, 5'h09, cap);
    pushExp(cap + 2, 3'd3, 1'b1, 1'b0);
    checkOutput("timeout_race_err", int'(train_err), 0);
    tick(3);
    fePulse();
    checkOutput("timeout_race_done", int'(resp_done), 1);
`endif

    tick(3);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
